dmem_responder: RTL and testbench

//  Responder side of the processor data-memory interface: accepts load/store requests
//  (byte/half/word, optional sign extension) and answers after a programmable wait-state

---
 rtl/dmem_responder.sv | 120 ++++++++++++
 tb/tb_dmem_responder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: big-endian byte store answering load/store requests
// after WAIT_CYCLES wait states with a single-cycle ready pulse.
module dmem_responder #(
    parameter int SIZE        = 16384,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic        write_enable,
    input  logic        mem_byte,
    input  logic        mem_half_word,
    input  logic        sign_extend,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ready,
    output logic        misalign_err
);

    localparam int AW = $clog2(SIZE);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q;
    logic          we_q, byte_q, half_q, sext_q, mis_q;
    logic [31:0]   wdata_q;
    logic [7:0]    mem [SIZE];

    logic          accept;
    logic          misalign;
    logic [AW-1:0] idx1, idx2, idx3;
    logic [31:0]   rdata;
    logic          unused_addr_hi;

    assign accept         = (state_q == S_IDLE) && req;
    assign unused_addr_hi = ^addr[31:AW];
    // Byte accesses are never misaligned; byte size wins over halfword.
    assign misalign = !mem_byte && (mem_half_word ? addr[0] : (addr[1:0] != 2'b00));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    cnt_d   = '0;
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'(WAIT_CYCLES - 1)) state_d = S_RESP;
                else                              cnt_d   = cnt_q + 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request fields are frozen at accept; later input changes are ignored.
    always_ff @(posedge clock) begin
        if (accept) begin
            idx_q   <= addr[AW-1:0];
            we_q    <= write_enable;
            byte_q  <= mem_byte;
            half_q  <= mem_half_word;
            sext_q  <= sign_extend;
            mis_q   <= misalign;
            wdata_q <= data_in;
        end
    end

    assign idx1 = idx_q + AW'(1);
    assign idx2 = idx_q + AW'(2);
    assign idx3 = idx_q + AW'(3);

    always_comb begin
        rdata = '0;
        if (byte_q)
            rdata = {{24{sext_q & mem[idx_q][7]}}, mem[idx_q]};
        else if (half_q)
            rdata = {{16{sext_q & mem[idx_q][7]}}, mem[idx_q], mem[idx1]};
        else
            rdata = {mem[idx_q], mem[idx1], mem[idx2], mem[idx3]};
    end

    assign ready        = (state_q == S_RESP);
    assign misalign_err = (state_q == S_RESP) && mis_q;
    assign data_out     = ((state_q == S_RESP) && !we_q && !mis_q) ? rdata : 32'h0;

    // Store commits on the edge leaving RESP; an async reset in RESP drops it.
    always_ff @(posedge clock) begin
        if ((state_q == S_RESP) && we_q && !mis_q) begin
            if (byte_q) begin
                mem[idx_q] <= wdata_q[7:0];
            end else if (half_q) begin
                mem[idx_q] <= wdata_q[15:8];
                mem[idx1]  <= wdata_q[7:0];
            end else begin
                mem[idx_q] <= wdata_q[31:24];
                mem[idx1]  <= wdata_q[23:16];
                mem[idx2]  <= wdata_q[15:8];
                mem[idx3]  <= wdata_q[7:0];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with 2 wait states, one with none.
module tb_dmem_responder;

    logic        clock;
    logic        reset_n;
    logic        req, req0;
    logic [31:0] addr;
    logic        write_enable, mem_byte, mem_half_word, sign_extend;
    logic [31:0] data_in;
    logic [31:0] dout, dout0;
    logic        rdy, rdy0, merr, merr0;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] rd;
    logic        me;
    int          lat;
    int          hits;
    logic [31:0] vals [4];

    dmem_responder #(.SIZE(16384), .WAIT_CYCLES(2)) u_dut (
        .clock(clock), .reset_n(reset_n), .req(req), .addr(addr),
        .write_enable(write_enable), .mem_byte(mem_byte), .mem_half_word(mem_half_word),
        .sign_extend(sign_extend), .data_in(data_in),
        .data_out(dout), .ready(rdy), .misalign_err(merr)
    );

    dmem_responder #(.SIZE(16384), .WAIT_CYCLES(0)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .req(req0), .addr(addr),
        .write_enable(write_enable), .mem_byte(mem_byte), .mem_half_word(mem_half_word),
        .sign_extend(sign_extend), .data_in(data_in),
        .data_out(dout0), .ready(rdy0), .misalign_err(merr0)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait (bounded) for ready, then confirm the pulse ends.
    task automatic access(input bit sel, input logic we, input logic by, input logic hw,
                          input logic se, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdo, output logic meo, output int lato);
        lato = 0; rdo = 32'h0; meo = 1'b0;
        addr = a; data_in = d; write_enable = we;
        mem_byte = by; mem_half_word = hw; sign_extend = se;
        if (sel) req0 = 1'b1; else req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            lato++;
            if (sel ? rdy0 : rdy) begin
                rdo = sel ? dout0 : dout;
                meo = sel ? merr0 : merr;
                break;
            end
        end
        req = 1'b0; req0 = 1'b0;
        @(posedge clock); #1;
        chk("ready_fall", {31'b0, sel ? rdy0 : rdy}, 32'h0);
        chk("dout_fall", sel ? dout0 : dout, 32'h0);
    endtask

    initial begin
        reset_n = 1'b0; req = 1'b0; req0 = 1'b0; addr = '0; data_in = '0;
        write_enable = 1'b0; mem_byte = 1'b0; mem_half_word = 1'b0; sign_extend = 1'b0;
        #12;
        chk("rst_ready", {31'b0, rdy}, 32'h0);
        chk("rst_merr", {31'b0, merr}, 32'h0);
        chk("rst_dout", dout, 32'h0);
        chk("rst_ready0", {31'b0, rdy0}, 32'h0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Word store/load, latency, signed byte load
        access(0, 1, 0, 0, 0, 32'h10, 32'hDEADBEEF, rd, me, lat);
        chk("st_w_lat", lat, 3);
        chk("st_w_dout", rd, 32'h0);
        access(0, 0, 0, 0, 0, 32'h10, 32'h0, rd, me, lat);
        chk("ld_w_lat", lat, 3);
        chk("ld_w_data", rd, 32'hDEADBEEF);
        chk("ld_w_merr", {31'b0, me}, 32'h0);
        access(0, 0, 1, 0, 1, 32'h11, 32'h0, rd, me, lat);
        chk("ld_b_sx", rd, 32'hFFFFFFAD);

        // Halfword loads, byte store lane
        access(0, 0, 0, 1, 0, 32'h12, 32'h0, rd, me, lat);
        chk("ld_h_zx", rd, 32'h0000BEEF);
        access(0, 0, 0, 1, 1, 32'h12, 32'h0, rd, me, lat);
        chk("ld_h_sx", rd, 32'hFFFFBEEF);
        access(0, 1, 1, 0, 0, 32'h13, 32'h0000007F, rd, me, lat);
        access(0, 0, 0, 0, 0, 32'h10, 32'h0, rd, me, lat);
        chk("ld_w_after_sb", rd, 32'hDEADBE7F);

        // Misalignment
        access(0, 0, 0, 0, 0, 32'h12, 32'h0, rd, me, lat);
        chk("mis_w_err", {31'b0, me}, 32'h1);
        chk("mis_w_data", rd, 32'h0);
        access(0, 0, 0, 1, 0, 32'h11, 32'h0, rd, me, lat);
        chk("mis_h_err", {31'b0, me}, 32'h1);
        chk("mis_h_data", rd, 32'h0);
        access(0, 1, 0, 0, 0, 32'h12, 32'h0, rd, me, lat);
        chk("mis_st_err", {31'b0, me}, 32'h1);
        access(0, 0, 0, 0, 0, 32'h10, 32'h0, rd, me, lat);
        chk("mis_mem_kept", rd, 32'hDEADBE7F);

        // Address wrap-around
        access(0, 1, 0, 0, 0, 32'h4020, 32'h01020304, rd, me, lat);
        access(0, 0, 0, 0, 0, 32'h20, 32'h0, rd, me, lat);
        chk("wrap_data", rd, 32'h01020304);

        // Zero wait states, back-to-back loads with req held
        vals[0] = 32'h11223344; vals[1] = 32'h55667788;
        vals[2] = 32'h99AABBCC; vals[3] = 32'hDDEEFF00;
        for (int i = 0; i < 4; i++) begin
            access(1, 1, 0, 0, 0, 32'h100 + 32'(4 * i), vals[i], rd, me, lat);
            chk("w0_st_lat", lat, 1);
        end
        write_enable = 1'b0; mem_byte = 1'b0; mem_half_word = 1'b0; sign_extend = 1'b0;
        addr = 32'h100; req0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            chk("b2b_ready_hi", {31'b0, rdy0}, 32'h1);
            chk("b2b_data", dout0, vals[i]);
            addr = 32'h100 + 32'(4 * (i + 1));
            if (i == 3) req0 = 1'b0;
            @(posedge clock); #1;
            chk("b2b_ready_lo", {31'b0, rdy0}, 32'h0);
        end

        // Reset during WAIT aborts the store
        access(0, 1, 0, 0, 0, 32'h40, 32'hCAFEF00D, rd, me, lat);
        addr = 32'h40; data_in = 32'h12345678; write_enable = 1'b1;
        mem_byte = 1'b0; mem_half_word = 1'b0; req = 1'b1;
        @(posedge clock); #1;
        req = 1'b0;
        reset_n = 1'b0;
        #2;
        chk("rst_wait_ready", {31'b0, rdy}, 32'h0);
        reset_n = 1'b1;
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            if (rdy) hits++;
        end
        chk("rst_no_pulse", hits, 0);
        access(0, 0, 0, 0, 0, 32'h40, 32'h0, rd, me, lat);
        chk("rst_mem_prior", rd, 32'hCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
